// File: rtl/mem_arbiter_if.sv
// Signal bundle between the memory arbiter, the bus controller data channel,
// the per-CPU icaches and the single-ported RAM.
`timescale 1ns/1ps
interface mem_arbiter_if #(
   parameter int CPUS = 2
);
   logic                     bus_dREN;
   logic                     bus_dWEN;
   logic [31:0]              bus_daddr;
   logic [31:0]              bus_dstore;
   logic [31:0]              bus_dload;
   logic                     bus_dwait;

   logic [CPUS-1:0]          iREN;
   logic [CPUS-1:0][31:0]    iaddr;
   logic [CPUS-1:0][31:0]    iload;
   logic [CPUS-1:0]          iwait;

   logic                     ramREN;
   logic                     ramWEN;
   logic [31:0]              ramaddr;
   logic [31:0]              ramstore;
   logic [31:0]              ramload;
   logic [1:0]               ramstate;
   logic                     ram_err;

   // Arbiter side.
   modport slave (
      input  bus_dREN, bus_dWEN, bus_daddr, bus_dstore,
      output bus_dload, bus_dwait,
      input  iREN, iaddr,
      output iload, iwait,
      output ramREN, ramWEN, ramaddr, ramstore,
      input  ramload, ramstate,
      output ram_err
   );

   // Requester and RAM side.
   modport master (
      output bus_dREN, bus_dWEN, bus_daddr, bus_dstore,
      input  bus_dload, bus_dwait,
      output iREN, iaddr,
      input  iload, iwait,
      input  ramREN, ramWEN, ramaddr, ramstore,
      output ramload, ramstate,
      input  ram_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter: bus data channel has priority, the two icaches
// share the remaining slots round-robin; a watchdog aborts hung accesses.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int CPUS    = 2,
   parameter int TIMEOUT = 255
) (
   input  logic          CLK,
   input  logic          nRST,
   mem_arbiter_if.slave  mif
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      INSTR = 2'd2
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   state_t      state_reg,   state_next;
   logic        igrant_reg,  igrant_next;
   logic        last_i_reg,  last_i_next;
   logic [7:0]  wdog_reg,    wdog_next;
   logic        ram_err_reg, ram_err_next;

   logic        ram_ren;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_store;
   logic        data_release;
   logic [31:0] data_load;
   logic        instr_release;
   logic [31:0] instr_load;

   logic        data_req;
   logic        ram_access;
   logic        ram_fault;

   assign data_req   = mif.bus_dREN | mif.bus_dWEN;
   assign ram_access = (mif.ramstate == RAM_ACCESS);
   // A RAM error and an expired watchdog are handled identically.
   assign ram_fault  = (mif.ramstate == RAM_ERROR) || (wdog_reg == 8'(TIMEOUT));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg   <= IDLE;
         igrant_reg  <= 1'b0;
         last_i_reg  <= 1'b1;
         wdog_reg    <= 8'd0;
         ram_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         igrant_reg  <= igrant_next;
         last_i_reg  <= last_i_next;
         wdog_reg    <= wdog_next;
         ram_err_reg <= ram_err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      igrant_next   = igrant_reg;
      last_i_next   = last_i_reg;
      wdog_next     = wdog_reg;
      ram_err_next  = ram_err_reg;
      ram_ren       = 1'b0;
      ram_wen       = 1'b0;
      ram_addr      = 32'd0;
      ram_store     = 32'd0;
      data_release  = 1'b0;
      data_load     = 32'd0;
      instr_release = 1'b0;
      instr_load    = 32'd0;

      case (state_reg)
         IDLE: begin
            wdog_next = 8'd0;
            if (data_req) begin
               state_next = DATA;
            end else if (mif.iREN[0] | mif.iREN[1]) begin
               if (mif.iREN[0] & mif.iREN[1]) begin
                  igrant_next = ~last_i_reg;
               end else begin
                  igrant_next = mif.iREN[1];
               end
               state_next = INSTR;
            end
         end

         DATA: begin
            ram_addr  = mif.bus_daddr;
            ram_store = mif.bus_dstore;
            ram_wen   = mif.bus_dWEN;
            ram_ren   = mif.bus_dREN & ~mif.bus_dWEN;
            if (!data_req) begin
               state_next = IDLE;
            end else if (ram_access) begin
               data_release = 1'b1;
               data_load    = mif.ramload;
               state_next   = IDLE;
            end else if (ram_fault) begin
               data_release = 1'b1;
               ram_err_next = 1'b1;
               state_next   = IDLE;
            end else begin
               wdog_next = wdog_reg + 8'd1;
            end
         end

         INSTR: begin
            ram_ren  = 1'b1;
            ram_addr = mif.iaddr[igrant_reg];
            if (!mif.iREN[igrant_reg]) begin
               state_next = IDLE;
            end else if (ram_access) begin
               instr_release = 1'b1;
               instr_load    = mif.ramload;
               last_i_next   = igrant_reg;
               state_next    = IDLE;
            end else if (ram_fault) begin
               // The round-robin pointer only advances on a completed fetch.
               instr_release = 1'b1;
               ram_err_next  = 1'b1;
               state_next    = IDLE;
            end else begin
               wdog_next = wdog_reg + 8'd1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mif.ramREN    = ram_ren;
   assign mif.ramWEN    = ram_wen;
   assign mif.ramaddr   = ram_addr;
   assign mif.ramstore  = ram_store;
   assign mif.bus_dwait = ~data_release;
   assign mif.bus_dload = data_load;
   assign mif.ram_err   = ram_err_reg;

   logic [CPUS-1:0]       iwait_vec;
   logic [CPUS-1:0][31:0] iload_vec;

   generate
      for (genvar gi = 0; gi < CPUS; gi++) begin : g_icache
         logic hit;
         assign hit           = instr_release && (igrant_reg == 1'(gi));
         assign iwait_vec[gi] = ~hit;
         assign iload_vec[gi] = hit ? instr_load : 32'd0;
      end
   endgenerate

   assign mif.iwait = iwait_vec;
   assign mif.iload = iload_vec;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: data path, icache round-robin, priority,
// write-over-read, error/watchdog handling and asynchronous reset.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

   logic CLK = 1'b0;
   logic nRST;
   int   total = 0;
   int   bad   = 0;

   always #5 CLK = ~CLK;

   mem_arbiter_if #(.CPUS(2)) mif ();

   mem_arbiter #(.CPUS(2), .TIMEOUT(255)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .mif  (mif)
   );

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic settle;
      @(negedge CLK);
   endtask

   task automatic test_reset;
      nRST = 1'b0;
      mif.bus_dREN = 1'b0; mif.bus_dWEN = 1'b0;
      mif.bus_daddr = 32'd0; mif.bus_dstore = 32'd0;
      mif.iREN = 2'b00; mif.iaddr = '0;
      mif.ramload = 32'd0; mif.ramstate = FREE;
      #3;
      total++; if (mif.bus_dwait !== 1'b1) begin bad++; $display("FAIL rst_dwait: got %b want 1", mif.bus_dwait); end
      total++; if (mif.iwait !== 2'b11) begin bad++; $display("FAIL rst_iwait: got %b want 11", mif.iwait); end
      total++; if (mif.ram_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", mif.ram_err); end
      step; step;
      nRST = 1'b1;
      settle;
      total++; if ({mif.ramREN, mif.ramWEN} !== 2'b00) begin bad++; $display("FAIL idle_ren_wen: got %b want 00", {mif.ramREN, mif.ramWEN}); end
      total++; if (mif.ramaddr !== 32'd0 || mif.ramstore !== 32'd0) begin bad++; $display("FAIL idle_addr_store: got %h/%h want 0/0", mif.ramaddr, mif.ramstore); end
      total++; if (mif.bus_dload !== 32'd0 || mif.iload !== 64'd0) begin bad++; $display("FAIL idle_loads: got %h/%h want 0/0", mif.bus_dload, mif.iload); end
      $display("reset: released, arbiter idle");
   endtask

   task automatic test_data_read;
      logic [1:0]  rs [5];
      logic [4:0]  req, e_ren, e_wait;
      logic [31:0] e_addr [5];
      logic [31:0] e_load [5];
      rs     = '{FREE, BUSY, BUSY, ACC, FREE};
      req    = 5'b01111;   // bit i = cycle i
      e_ren  = 5'b01110;
      e_wait = 5'b10111;
      e_addr = '{32'h0, 32'h100, 32'h100, 32'h100, 32'h0};
      e_load = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
      mif.bus_daddr = 32'h100;
      mif.ramload = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
         step;
         mif.bus_dREN = req[i];
         mif.ramstate = rs[i];
         settle;
         total++; if (mif.ramREN !== e_ren[i]) begin bad++; $display("FAIL rd_ren_c%0d: got %b want %b", i, mif.ramREN, e_ren[i]); end
         total++; if (mif.ramaddr !== e_addr[i]) begin bad++; $display("FAIL rd_addr_c%0d: got %h want %h", i, mif.ramaddr, e_addr[i]); end
         total++; if (mif.bus_dwait !== e_wait[i]) begin bad++; $display("FAIL rd_wait_c%0d: got %b want %b", i, mif.bus_dwait, e_wait[i]); end
         total++; if (mif.bus_dload !== e_load[i]) begin bad++; $display("FAIL rd_load_c%0d: got %h want %h", i, mif.bus_dload, e_load[i]); end
      end
      $display("data read: addr=00000100 data=deadbeef");
   endtask

   task automatic test_icache_round_robin;
      logic [1:0]  rs [9];
      logic [1:0]  e_iwait [9];
      logic [31:0] e_addr [9];
      logic [63:0] e_il;
      logic [31:0] ld;
      rs      = '{FREE, BUSY, ACC, FREE, BUSY, ACC, FREE, BUSY, ACC};
      e_iwait = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b10};
      e_addr  = '{32'h0, 32'h200, 32'h200, 32'h0, 32'h300, 32'h300, 32'h0, 32'h200, 32'h200};
      mif.iaddr[0] = 32'h200;
      mif.iaddr[1] = 32'h300;
      for (int i = 0; i < 9; i++) begin
         step;
         mif.iREN = 2'b11;
         mif.ramstate = rs[i];
         ld = 32'hA000_0000 | 32'(i);
         mif.ramload = ld;
         e_il = 64'd0;
         if (e_iwait[i][0] == 1'b0) e_il[31:0]  = ld;
         if (e_iwait[i][1] == 1'b0) e_il[63:32] = ld;
         settle;
         total++; if (mif.iwait !== e_iwait[i]) begin bad++; $display("FAIL rr_iwait_c%0d: got %b want %b", i, mif.iwait, e_iwait[i]); end
         total++; if (mif.ramaddr !== e_addr[i]) begin bad++; $display("FAIL rr_addr_c%0d: got %h want %h", i, mif.ramaddr, e_addr[i]); end
         total++; if (mif.iload !== e_il) begin bad++; $display("FAIL rr_iload_c%0d: got %h want %h", i, mif.iload, e_il); end
         if (e_iwait[i] != 2'b11) $display("fetch: cpu=%0d data=%h", (e_iwait[i] == 2'b10) ? 0 : 1, ld);
      end
      step;
      mif.iREN = 2'b00;
      mif.ramstate = FREE;
   endtask

   task automatic test_data_priority;
      mif.iaddr[0] = 32'h200;
      step;
      mif.iREN = 2'b01; mif.bus_dWEN = 1'b1;
      mif.bus_daddr = 32'h40; mif.bus_dstore = 32'h12345678;
      settle;
      total++; if (mif.ramWEN !== 1'b0) begin bad++; $display("FAIL pri_idle_wen: got %b want 0", mif.ramWEN); end
      step;
      mif.ramstate = ACC;
      settle;
      total++; if ({mif.ramWEN, mif.ramREN} !== 2'b10) begin bad++; $display("FAIL pri_wen_ren: got %b want 10", {mif.ramWEN, mif.ramREN}); end
      total++; if (mif.ramstore !== 32'h12345678 || mif.ramaddr !== 32'h40) begin bad++; $display("FAIL pri_store_addr: got %h/%h want 12345678/00000040", mif.ramstore, mif.ramaddr); end
      total++; if (mif.bus_dwait !== 1'b0 || mif.iwait !== 2'b11) begin bad++; $display("FAIL pri_waits: got %b/%b want 0/11", mif.bus_dwait, mif.iwait); end
      step;
      mif.bus_dWEN = 1'b0; mif.ramstate = FREE;
      settle;
      total++; if (mif.ramREN !== 1'b0 || mif.iwait !== 2'b11) begin bad++; $display("FAIL pri_gap: got ren=%b iwait=%b want 0/11", mif.ramREN, mif.iwait); end
      step;
      mif.ramstate = ACC; mif.ramload = 32'h55;
      settle;
      total++; if (mif.ramREN !== 1'b1 || mif.ramaddr !== 32'h200) begin bad++; $display("FAIL pri_fetch_drive: got ren=%b addr=%h want 1/00000200", mif.ramREN, mif.ramaddr); end
      total++; if (mif.iwait !== 2'b10 || mif.iload[0] !== 32'h55) begin bad++; $display("FAIL pri_fetch_done: got iwait=%b iload0=%h want 10/00000055", mif.iwait, mif.iload[0]); end
      step;
      mif.iREN = 2'b00; mif.ramstate = FREE;
      $display("priority: write 12345678 then fetch cpu0");
   endtask

   task automatic test_write_wins;
      step;
      mif.bus_dREN = 1'b1; mif.bus_dWEN = 1'b1; mif.bus_daddr = 32'h80;
      step;
      mif.ramstate = BUSY;
      settle;
      total++; if ({mif.ramWEN, mif.ramREN} !== 2'b10) begin bad++; $display("FAIL ww_wen_ren: got %b want 10", {mif.ramWEN, mif.ramREN}); end
      step;
      mif.ramstate = ACC;
      settle;
      total++; if (mif.bus_dwait !== 1'b0) begin bad++; $display("FAIL ww_wait: got %b want 0", mif.bus_dwait); end
      step;
      mif.bus_dREN = 1'b0; mif.bus_dWEN = 1'b0; mif.ramstate = FREE;
      $display("write wins: addr=00000080");
   endtask

   task automatic test_error_response;
      step;
      mif.bus_dREN = 1'b1; mif.bus_daddr = 32'h44; mif.ramload = 32'hFFFFFFFF;
      step;
      mif.ramstate = ERR;
      settle;
      total++; if (mif.bus_dwait !== 1'b0 || mif.bus_dload !== 32'd0) begin bad++; $display("FAIL err_release: got wait=%b load=%h want 0/00000000", mif.bus_dwait, mif.bus_dload); end
      step;
      mif.bus_dREN = 1'b0; mif.ramstate = FREE;
      settle;
      total++; if (mif.ram_err !== 1'b1) begin bad++; $display("FAIL err_flag: got %b want 1", mif.ram_err); end
      $display("error response: ram_err set");
   endtask

   task automatic test_reset_mid_data;
      mif.iaddr[0] = 32'h200; mif.iaddr[1] = 32'h300;
      step;
      mif.bus_dWEN = 1'b1; mif.bus_daddr = 32'h10;
      step;
      mif.ramstate = BUSY;
      settle;
      total++; if (mif.ramWEN !== 1'b1) begin bad++; $display("FAIL mid_wen_before: got %b want 1", mif.ramWEN); end
      #2 nRST = 1'b0;
      #1;
      total++; if (mif.bus_dwait !== 1'b1 || mif.ramWEN !== 1'b0) begin bad++; $display("FAIL mid_async: got wait=%b wen=%b want 1/0", mif.bus_dwait, mif.ramWEN); end
      total++; if (mif.ram_err !== 1'b0) begin bad++; $display("FAIL mid_err_clr: got %b want 0", mif.ram_err); end
      step;
      mif.bus_dWEN = 1'b0; mif.ramstate = FREE;
      step;
      nRST = 1'b1;
      mif.iREN = 2'b11;   // tie: reset pointer must favour CPU0
      settle;
      total++; if (mif.iwait !== 2'b11 || mif.ramREN !== 1'b0) begin bad++; $display("FAIL mid_idle: got iwait=%b ren=%b want 11/0", mif.iwait, mif.ramREN); end
      step;
      mif.ramstate = ACC; mif.ramload = 32'h77;
      settle;
      total++; if (mif.ramaddr !== 32'h200 || mif.iwait !== 2'b10) begin bad++; $display("FAIL mid_grant0: got addr=%h iwait=%b want 00000200/10", mif.ramaddr, mif.iwait); end
      step;
      mif.iREN = 2'b00; mif.ramstate = FREE;
      $display("reset mid-data: fetch cpu0 after reset");
   endtask

   task automatic test_watchdog;
      bit        released = 0;
      int        rel_cycle = 0;
      logic [1:0]  rel_iwait = 2'b11;
      logic [31:0] rel_iload = 32'hX;
      mif.iaddr[1] = 32'h300;
      step;
      mif.iREN = 2'b10; mif.ramload = 32'hCAFEF00D;
      for (int n = 1; n <= 300 && !released; n++) begin
         step;
         mif.ramstate = BUSY;
         settle;
         if (mif.iwait !== 2'b11) begin
            released  = 1;
            rel_cycle = n;
            rel_iwait = mif.iwait;
            rel_iload = mif.iload[1];
         end
      end
      total++; if (rel_cycle != 256) begin bad++; $display("FAIL wd_cycle: got %0d want 256", rel_cycle); end
      total++; if (rel_iwait !== 2'b01 || rel_iload !== 32'd0) begin bad++; $display("FAIL wd_release: got iwait=%b iload1=%h want 01/00000000", rel_iwait, rel_iload); end
      step;
      mif.iREN = 2'b00; mif.ramstate = FREE;
      settle;
      total++; if (mif.ram_err !== 1'b1 || mif.iwait !== 2'b11) begin bad++; $display("FAIL wd_err: got err=%b iwait=%b want 1/11", mif.ram_err, mif.iwait); end
      repeat (5) step;
      settle;
      total++; if (mif.ram_err !== 1'b1) begin bad++; $display("FAIL wd_sticky: got %b want 1", mif.ram_err); end
      step;
      nRST = 1'b0;
      #1;
      total++; if (mif.ram_err !== 1'b0) begin bad++; $display("FAIL wd_err_reset: got %b want 0", mif.ram_err); end
      step;
      nRST = 1'b1;
      $display("watchdog: abort after %0d granted cycles", rel_cycle);
   endtask

   initial begin
      test_reset;
      test_data_read;
      test_icache_round_robin;
      test_data_priority;
      test_write_wins;
      test_error_response;
      test_reset_mid_data;
      test_watchdog;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL sim_timeout: got no finish want finish");
      $fatal(1, "simulation time limit");
   end

endmodule
